// File: rtl/cvp_bcd_accumulator.sv
// cvp_bcd_accumulator: iterative N-digit BCD to binary converter with peak hold.
// Optional macro CVP_BCD_CHECK_EN flags non-BCD digits and suppresses errored results.
module cvp_bcd_accumulator #(
    parameter int DIGITS = 3,
    parameter int OUT_W  = 10
) (
    input  logic                  iClk,
    input  logic                  iReset,
    input  logic                  iCle,
    input  logic                  iPeakClr,
    input  logic [4*DIGITS-1:0]   ivDigits,
    output logic [OUT_W-1:0]      ovValue,
    output logic [OUT_W-1:0]      ovPeak,
    output logic                  oValid,
    output logic                  oBusy,
    output logic                  oSat,
    output logic                  oBcdErr
);
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [OUT_W+3:0] MAX = {4'b0, {OUT_W{1'b1}}};
    localparam logic [OUT_W+3:0] TEN = (OUT_W + 4)'(10);
    typedef enum logic {IDLE, CONV} state_t;
    state_t state_q, state_d;
    logic [4*DIGITS-1:0] sr_q, sr_d;
    logic [OUT_W-1:0] acc_q, acc_d, value_q, value_d, peak_q, peak_d, res;
    logic [CW-1:0] cnt_q, cnt_d;
    logic sat_q, sat_d, err_q, err_d, valid_q, valid_d, osat_q, osat_d, oerr_q, oerr_d;
    logic [3:0] msd;
    logic [OUT_W+3:0] wide;
    logic step_sat, step_err, last, err_f, good;
    always_comb begin
        msd = sr_q[4*DIGITS-1 -: 4];
        wide = {4'b0, acc_q} * TEN + (OUT_W + 4)'(msd);
        step_sat = wide > MAX;
`ifdef CVP_BCD_CHECK_EN
        step_err = msd > 4'd9;
`else
        step_err = 1'b0;
`endif
        res = step_sat ? {OUT_W{1'b1}} : wide[OUT_W-1:0];
        last = (state_q == CONV) && (cnt_q == CW'(1));
        err_f = err_q | step_err;
        good = last && !err_f;
        state_d = state_q;
        sr_d = sr_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        sat_d = sat_q;
        err_d = err_q;
        value_d = value_q;
        osat_d = osat_q;
        oerr_d = oerr_q;
        valid_d = 1'b0;
        if (state_q == IDLE && iCle) begin
            sr_d = ivDigits;
            acc_d = '0;
            sat_d = 1'b0;
            err_d = 1'b0;
            cnt_d = CW'(DIGITS);
            state_d = CONV;
        end else if (state_q == CONV) begin
            acc_d = res;
            sat_d = sat_q | step_sat;
            err_d = err_f;
            sr_d = sr_q << 4;
            cnt_d = cnt_q - CW'(1);
            if (last) begin
                state_d = IDLE;
                valid_d = 1'b1;
                value_d = err_f ? '0 : res;
                osat_d = sat_d;
                oerr_d = err_f;
            end
        end
        // A coincident clear restarts the peak from this result (or zero if none)
        peak_d = iPeakClr ? (good ? res : '0) : ((good && res > peak_q) ? res : peak_q);
    end
    always_ff @(posedge iClk) begin
        if (iReset) begin
            state_q <= IDLE;
            sr_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
            err_q <= 1'b0;
            value_q <= '0;
            peak_q <= '0;
            valid_q <= 1'b0;
            osat_q <= 1'b0;
            oerr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q <= sr_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            err_q <= err_d;
            value_q <= value_d;
            peak_q <= peak_d;
            valid_q <= valid_d;
            osat_q <= osat_d;
            oerr_q <= oerr_d;
        end
    end
    assign ovValue = value_q;
    assign ovPeak = peak_q;
    assign oValid = valid_q;
    assign oBusy = (state_q == CONV);
    assign oSat = osat_q;
    assign oBcdErr = oerr_q;
endmodule

// File: tb/tb_cvp_bcd_accumulator.sv
// tb_cvp_bcd_accumulator: directed checks on three parameterisations of the BCD accumulator.
module tb_cvp_bcd_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic cle_a = 0, clr_a = 0;
    logic [11:0] dig_a = '0;
    logic [9:0] val_a, peak_a;
    logic valid_a, busy_a, sat_a, err_a;

    logic cle_b = 0, clr_b = 0;
    logic [11:0] dig_b = '0;
    logic [7:0] val_b, peak_b;
    logic valid_b, busy_b, sat_b, err_b;

    logic cle_c = 0, clr_c = 0;
    logic [3:0] dig_c = '0;
    logic [3:0] val_c, peak_c;
    logic valid_c, busy_c, sat_c, err_c;

    int checks = 0;
    int errors = 0;

    cvp_bcd_accumulator #(.DIGITS(3), .OUT_W(10)) dut_a (
        .iClk(clk), .iReset(rst), .iCle(cle_a), .iPeakClr(clr_a), .ivDigits(dig_a),
        .ovValue(val_a), .ovPeak(peak_a), .oValid(valid_a), .oBusy(busy_a),
        .oSat(sat_a), .oBcdErr(err_a));
    cvp_bcd_accumulator #(.DIGITS(3), .OUT_W(8)) dut_b (
        .iClk(clk), .iReset(rst), .iCle(cle_b), .iPeakClr(clr_b), .ivDigits(dig_b),
        .ovValue(val_b), .ovPeak(peak_b), .oValid(valid_b), .oBusy(busy_b),
        .oSat(sat_b), .oBcdErr(err_b));
    cvp_bcd_accumulator #(.DIGITS(1), .OUT_W(4)) dut_c (
        .iClk(clk), .iReset(rst), .iCle(cle_c), .iPeakClr(clr_c), .ivDigits(dig_c),
        .ovValue(val_c), .ovPeak(peak_c), .oValid(valid_c), .oBusy(busy_c),
        .oSat(sat_c), .oBcdErr(err_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Leaves the bench in the oValid cycle of the conversion.
    task automatic conv_a(input logic [11:0] d, input logic pclr);
        dig_a = d; cle_a = 1; step(); cle_a = 0;
        step(); step();
        clr_a = pclr; step(); clr_a = 0;
    endtask

    task automatic conv_b(input logic [11:0] d);
        dig_b = d; cle_b = 1; step(); cle_b = 0;
        step(); step(); step();
    endtask

    initial begin
        step(); step();
        rst = 0;
        chk("rst_value", val_a, 0);
        chk("rst_peak", peak_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_sat", sat_a, 0);
        chk("rst_err", err_a, 0);
        // 1: basic conversion with busy/valid timing
        dig_a = 12'h123; cle_a = 1; step(); cle_a = 0;
        chk("t1_busy0", busy_a, 1);
        chk("t1_valid0", valid_a, 0);
        step(); chk("t1_busy1", busy_a, 1);
        step(); chk("t1_busy2", busy_a, 1);
        chk("t1_valid2", valid_a, 0);
        step();
        chk("t1_busy3", busy_a, 0);
        chk("t1_valid3", valid_a, 1);
        chk("t1_value", val_a, 123);
        chk("t1_sat", sat_a, 0);
        chk("t1_peak", peak_a, 123);
        step(); chk("t1_valid_drop", valid_a, 0);
        chk("t1_hold", val_a, 123);
        // 2: peak tracking and clears
        conv_a(12'h045, 0); step();
        chk("t2_v045", val_a, 45); chk("t2_p045", peak_a, 123);
        conv_a(12'h200, 0); step();
        chk("t2_p200", peak_a, 200);
        conv_a(12'h200, 0); step();
        chk("t2_p200b", peak_a, 200);
        clr_a = 1; step(); clr_a = 0;
        chk("t2_clr", peak_a, 0);
        conv_a(12'h123, 0); step();
        chk("t2_p123", peak_a, 123);
        conv_a(12'h007, 1);
        chk("t2_clr_final", peak_a, 7);
        chk("t2_v007", val_a, 7);
        step();
        // 3: saturation on the 8-bit instance
        conv_b(12'h300);
        chk("t3_valid", valid_b, 1);
        chk("t3_v300", val_b, 255);
        chk("t3_sat", sat_b, 1);
        chk("t3_peak", peak_b, 255);
        step();
        conv_b(12'h042);
        chk("t3_v042", val_b, 42);
        chk("t3_sat_clr", sat_b, 0);
        chk("t3_peak_hold", peak_b, 255);
        step();
        // 4: iCle during CONV ignored, input changes ignored
        dig_a = 12'h123; cle_a = 1; step(); cle_a = 0;
        dig_a = 12'h999; cle_a = 1; step(); cle_a = 0;
        step(); chk("t4_nov", valid_a, 0);
        step(); chk("t4_valid", valid_a, 1);
        chk("t4_value", val_a, 123);
        step(); chk("t4_single0", valid_a, 0);
        step(); chk("t4_single1", valid_a, 0);
        chk("t4_idle", busy_a, 0);
        // 4b: iCle held high -> one result every DIGITS+1 cycles
        dig_a = 12'h321; cle_a = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("t4_b2b_%0d", i), valid_a, (i == 4 || i == 8) ? 1 : 0);
        end
        cle_a = 0;
        chk("t4_b2b_value", val_a, 321);
        step();
        // 5: reset aborts a conversion
        dig_a = 12'h456; cle_a = 1; step(); cle_a = 0;
        step();
        rst = 1; step(); rst = 0;
        chk("t5_value", val_a, 0);
        chk("t5_peak", peak_a, 0);
        chk("t5_valid", valid_a, 0);
        chk("t5_busy", busy_a, 0);
        chk("t5_sat", sat_a, 0);
        step(); chk("t5_nov1", valid_a, 0);
        step(); chk("t5_nov2", valid_a, 0);
        conv_a(12'h456, 0);
        chk("t5_v456", val_a, 456);
        chk("t5_p456", peak_a, 456);
        step();
        // 6: non-BCD digit
        conv_a(12'h1A3, 0);
        chk("t6_valid", valid_a, 1);
`ifdef CVP_BCD_CHECK_EN
        chk("t6_err", err_a, 1);
        chk("t6_value", val_a, 0);
`else
        chk("t6_err", err_a, 0);
        chk("t6_value", val_a, 203);
`endif
        chk("t6_peak", peak_a, 456);
        step();
        // DIGITS=1 boundary: single CONV edge
        dig_c = 4'd9; cle_c = 1; step(); cle_c = 0;
        chk("d1_busy", busy_c, 1);
        step();
        chk("d1_valid", valid_c, 1);
        chk("d1_busy_done", busy_c, 0);
        chk("d1_value", val_c, 9);
        chk("d1_peak", peak_c, 9);
        step();
        dig_c = 4'd7; cle_c = 1; step(); cle_c = 0; step();
        chk("d1_value7", val_c, 7);
        chk("d1_peak_hold", peak_c, 9);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
